// File: rtl/uart_reg_ctrl.sv
// Single-port access sequencer for the UART register block: arbitrates RX capture, status updates and host accesses.
// Optional: define UART_AUTO_START_EN to follow every host TX data write with an automatic CTRL start write.
module uart_reg_ctrl #(
   parameter logic [4:0] IDLE_ADDR = 5'h1F,
   parameter logic [4:0] ADDR_TX   = 5'h00,
   parameter logic [4:0] ADDR_RX   = 5'h04,
   parameter logic [4:0] ADDR_CFG  = 5'h08,
   parameter logic [4:0] ADDR_CTRL = 5'h0C,
   parameter logic [4:0] ADDR_STT  = 5'h10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        host_wr_req,
   input  logic        host_rd_req,
   input  logic [4:0]  host_addr,
   input  logic [31:0] host_wdata,
   output logic        host_ack,
   input  logic        tx_done_evt,
   input  logic        rx_done_evt,
   input  logic        parity_err_evt,
   input  logic        stt_read_tx_done,
   input  logic        stt_read_rx_done,
   input  logic        stt_read_parity_error,
   output logic [4:0]  reg_address,
   output logic [31:0] data_write_to_reg,
   output logic        set_tx_done,
   output logic        set_rx_done,
   output logic        set_parity_error,
   output logic        read_tx_data,
   output logic        read_rx_data,
   output logic        busy,
   output logic        rx_overrun
);

   typedef enum logic [2:0] {
      IDLE,
      RX_CAP,
      STT_UPD,
      HOST_WR,
      HOST_RD
`ifdef UART_AUTO_START_EN
      , AUTO_START
`endif
   } state_t;

   state_t state, nxt;
   logic   rx_pend, stt_pend;
   logic   sh_tx, sh_rx, sh_pe;
   logic   wr_seen, rd_seen;
   logic   sh_tx_n, sh_rx_n, sh_pe_n;
   logic   host_state, host_nxt, ovr_clr;

   always_comb begin
      // set beats clear when both land in the same cycle
      sh_tx_n = tx_done_evt | (sh_tx & ~stt_read_tx_done);
      sh_rx_n = rx_done_evt | (sh_rx & ~stt_read_rx_done);
      sh_pe_n = (rx_done_evt & parity_err_evt) | (sh_pe & ~stt_read_parity_error);

`ifdef UART_AUTO_START_EN
      host_state = (state == HOST_WR) || (state == HOST_RD) || (state == AUTO_START);
`else
      host_state = (state == HOST_WR) || (state == HOST_RD);
`endif

      // one-cycle states hand straight back to arbitration instead of parking in IDLE
      nxt = IDLE;
      if (state == RX_CAP)
         nxt = STT_UPD;
`ifdef UART_AUTO_START_EN
      else if ((state == HOST_WR) && (host_addr == ADDR_TX))
         nxt = AUTO_START;
`endif
      else if (rx_pend)
         nxt = RX_CAP;
      else if (stt_pend && (state != STT_UPD))
         nxt = STT_UPD;
      else if (wr_seen)
         nxt = HOST_WR;
      else if (rd_seen)
         nxt = HOST_RD;

      host_nxt = (nxt == HOST_WR) || (nxt == HOST_RD);
      ovr_clr  = (nxt == HOST_WR) && (host_addr == ADDR_STT) && host_wdata[31];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         rx_pend           <= 1'b0;
         stt_pend          <= 1'b0;
         sh_tx             <= 1'b0;
         sh_rx             <= 1'b0;
         sh_pe             <= 1'b0;
         wr_seen           <= 1'b0;
         rd_seen           <= 1'b0;
         reg_address       <= IDLE_ADDR;
         data_write_to_reg <= '0;
         set_tx_done       <= 1'b0;
         set_rx_done       <= 1'b0;
         set_parity_error  <= 1'b0;
         read_tx_data      <= 1'b0;
         read_rx_data      <= 1'b0;
         host_ack          <= 1'b0;
         busy              <= 1'b0;
         rx_overrun        <= 1'b0;
      end else begin
         sh_tx      <= sh_tx_n;
         sh_rx      <= sh_rx_n;
         sh_pe      <= sh_pe_n;
         rx_pend    <= rx_done_evt | (rx_pend & (state != RX_CAP));
         stt_pend   <= tx_done_evt | (state == RX_CAP) | (stt_pend & (state != STT_UPD));
         rx_overrun <= (rx_overrun & ~ovr_clr) | (rx_done_evt & rx_pend);
         // a request already being served must be dropped by the host before it is seen again
         wr_seen    <= host_wr_req & ~host_state & ~host_nxt;
         rd_seen    <= host_rd_req & ~host_state & ~host_nxt;
         state      <= nxt;
         busy       <= (nxt != IDLE);

         reg_address      <= IDLE_ADDR;
         set_tx_done      <= 1'b0;
         set_rx_done      <= 1'b0;
         set_parity_error <= 1'b0;
         read_tx_data     <= 1'b0;
         read_rx_data     <= 1'b0;
         host_ack         <= 1'b0;

         case (nxt)
            RX_CAP: reg_address <= ADDR_RX;
            STT_UPD: begin
               reg_address      <= ADDR_STT;
               set_tx_done      <= sh_tx_n;
               set_rx_done      <= sh_rx_n;
               set_parity_error <= sh_pe_n;
            end
            HOST_WR: begin
               if (host_addr inside {ADDR_TX, ADDR_CFG, ADDR_CTRL})
                  reg_address <= host_addr;
               if (host_addr inside {ADDR_TX, ADDR_CFG, ADDR_CTRL, ADDR_STT})
                  data_write_to_reg <= host_wdata;
`ifdef UART_AUTO_START_EN
               host_ack <= (host_addr != ADDR_TX);
`else
               host_ack <= 1'b1;
`endif
            end
            HOST_RD: begin
               read_tx_data <= (host_addr == ADDR_TX);
               read_rx_data <= (host_addr == ADDR_RX);
               host_ack     <= 1'b1;
            end
`ifdef UART_AUTO_START_EN
            AUTO_START: begin
               reg_address       <= ADDR_CTRL;
               data_write_to_reg <= 32'h1;
               host_ack          <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
